dual_issue_scheduler: RTL and testbench

//  Issue-stage scheduler for the dual-issue pipeline. Takes an in-order pair of decoded register addresses
//  (slot A older, slot B younger). Decides each cycle whether to issue A+B together, A alone, or stall.

---
 rtl/dual_issue_scheduler_if.sv | 38 +++
 rtl/dual_issue_scheduler.sv | 127 ++++++++++++
 tb/tb_dual_issue_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dual_issue_scheduler_if.sv
// Instruction-pair handshake between the register-address decoders and the dual-issue scheduler.
// Latency: none, this is wiring only; the issue decisions are combinational in the scheduler.
// Backpressure: in_ready low holds the pair upstream; issue_a/issue_b report what left this cycle.
interface dual_issue_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       a_rs1;
    logic [4:0]       a_rs2;
    logic [4:0]       a_rd;
    logic             a_is_load;
    logic             b_valid;
    logic [4:0]       b_rs1;
    logic [4:0]       b_rs2;
    logic [4:0]       b_rd;
    logic             b_is_load;
    logic             issue_a;
    logic             issue_b;
    logic [CNT_W-1:0] stall_cycles;

    // Decoder side: presents the pair and observes the issue decisions.
    modport master (
        output flush, in_valid,
        output a_rs1, a_rs2, a_rd, a_is_load,
        output b_valid, b_rs1, b_rs2, b_rd, b_is_load,
        input  in_ready, issue_a, issue_b, stall_cycles
    );

    // Scheduler side.
    modport slave (
        input  flush, in_valid,
        input  a_rs1, a_rs2, a_rd, a_is_load,
        input  b_valid, b_rs1, b_rs2, b_rd, b_is_load,
        output in_ready, issue_a, issue_b, stall_cycles
    );
endinterface

// File: rtl/dual_issue_scheduler.sv
// Issue-stage scheduler: issues an in-order pair together, A alone, or stalls, using a load scoreboard.
// Latency: zero; issue_a/issue_b/in_ready are combinational from state, inputs and scoreboard.
// Backpressure: in_ready only when the whole pair has issued; a split pair holds B in S_B_ONLY.
module dual_issue_scheduler #(
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dual_issue_scheduler_if.slave bus
);

    typedef enum logic {
        S_PAIR   = 1'b0,
        S_B_ONLY = 1'b1
    } state_t;

    // The counter is loaded at the end of the issue cycle, so it holds the number of
    // cycles still to wait after that cycle: a consumer may go LOAD_LAT cycles after the load.
    localparam logic [2:0] SET_VAL = 3'(LOAD_LAT - 1);

    state_t           state;
    logic [2:0]       cnt [1:31];
    logic [31:0]      busy;
    logic [CNT_W-1:0] stall_q;

    logic a_ready;
    logic b_src_ok;
    logic raw_hit;
    logic waw_hit;
    logic pair_ok;
    logic issue_a;
    logic issue_b;
    logic in_ready;
    logic set_a;
    logic set_b;
    logic stall_now;

    // Busy vector from the scoreboard; x0 is never tracked.
    always_comb begin
        busy = '0;
        for (int r = 1; r < 32; r++) begin
            busy[r] = (cnt[r] != 3'd0);
        end
    end

    // Hazard checks and issue decisions.
    always_comb begin
        a_ready  = bus.in_valid & ~busy[bus.a_rs1] & ~busy[bus.a_rs2];
        b_src_ok = ~busy[bus.b_rs1] & ~busy[bus.b_rs2];
        raw_hit  = (bus.a_rd != 5'd0) && ((bus.b_rs1 == bus.a_rd) || (bus.b_rs2 == bus.a_rd));
        waw_hit  = (bus.a_rd != 5'd0) && (bus.b_rd == bus.a_rd);
        pair_ok  = bus.b_valid & ~raw_hit & ~waw_hit & ~(bus.a_is_load & bus.b_is_load) & b_src_ok;

        issue_a  = 1'b0;
        issue_b  = 1'b0;
        in_ready = 1'b0;
        if (rst_n && !bus.flush) begin
            if (state == S_PAIR) begin
                if (a_ready) begin
                    issue_a  = 1'b1;
                    issue_b  = pair_ok;
                    in_ready = pair_ok | ~bus.b_valid;
                end
            end else begin
                // A already left; B waits only on the scoreboard.
                if (bus.in_valid && b_src_ok) begin
                    issue_b  = 1'b1;
                    in_ready = 1'b1;
                end
            end
        end

        set_a     = issue_a & bus.a_is_load & (bus.a_rd != 5'd0);
        set_b     = issue_b & bus.b_is_load & (bus.b_rd != 5'd0);
        stall_now = bus.in_valid & ~issue_a & ~issue_b;
    end

    // Scoreboard: a load issue loads the counter, otherwise every busy counter counts down.
    always_ff @(posedge clk) begin
        for (int r = 1; r < 32; r++) begin
            if (!rst_n || bus.flush) begin
                cnt[r] <= 3'd0;
            end else if ((set_a && bus.a_rd == 5'(r)) || (set_b && bus.b_rd == 5'(r))) begin
                cnt[r] <= SET_VAL;
            end else if (cnt[r] != 3'd0) begin
                cnt[r] <= cnt[r] - 3'd1;
            end
        end
    end

    // Pair FSM: S_B_ONLY remembers that A of the current pair has already issued.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            state <= S_PAIR;
        end else begin
            case (state)
                S_PAIR: begin
                    if (issue_a && !in_ready) begin
                        state <= S_B_ONLY;
                    end
                end
                S_B_ONLY: begin
                    if (issue_b) begin
                        state <= S_PAIR;
                    end
                end
                default: state <= S_PAIR;
            endcase
        end
    end

    // Saturating stall counter; a flush does not clear it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (stall_now && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.issue_a      = issue_a;
    assign bus.issue_b      = issue_b;
    assign bus.in_ready     = in_ready;
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler with LOAD_LAT=2, CNT_W=16.
// Latency: outputs are checked 1 time unit after inputs settle, between clock edges.
// Backpressure: each vector states the expected issue_a/issue_b/in_ready by hand.
module tb_dual_issue_scheduler;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   exp_stall;

    dual_issue_scheduler_if #(.CNT_W(16)) bus ();

    dual_issue_scheduler #(.LOAD_LAT(2), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Let combinational outputs settle, then compare the three handshake outputs.
    task automatic chk_out(input string tag, input logic ea, input logic eb, input logic er);
        #1;
        chk({tag, ".issue_a"},  32'(bus.issue_a),  32'(ea));
        chk({tag, ".issue_b"},  32'(bus.issue_b),  32'(eb));
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(er));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic [4:0] ars1, input logic [4:0] ars2, input logic [4:0] ard,
                        input logic ald, input logic bv, input logic [4:0] brs1,
                        input logic [4:0] brs2, input logic [4:0] brd, input logic bld);
        bus.in_valid  = 1'b1;
        bus.a_rs1     = ars1;
        bus.a_rs2     = ars2;
        bus.a_rd      = ard;
        bus.a_is_load = ald;
        bus.b_valid   = bv;
        bus.b_rs1     = brs1;
        bus.b_rs2     = brs2;
        bus.b_rd      = brd;
        bus.b_is_load = bld;
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        exp_stall = 0;
        rst_n     = 1'b0;
        bus.flush = 1'b0;
        pair(5'd2, 5'd3, 5'd1, 1'b0, 1'b1, 5'd5, 5'd6, 5'd4, 1'b0);

        // Reset held two cycles with a valid pair present.
        step();
        chk_out("rst0", 1'b0, 1'b0, 1'b0);
        step();
        chk_out("rst1", 1'b0, 1'b0, 1'b0);
        chk("rst.stall", 32'(bus.stall_cycles), 32'd0);
        rst_n = 1'b1;

        // Independent pair issues together right after release.
        chk_out("indep", 1'b1, 1'b1, 1'b1);
        step();

        // Nothing presented: no issue, no stall count.
        bus.in_valid = 1'b0;
        chk_out("idle", 1'b0, 1'b0, 1'b0);
        step();
        chk("idle.stall", 32'(bus.stall_cycles), 32'd0);

        // Intra-pair RAW on x5 splits the pair.
        pair(5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 5'd5, 5'd0, 5'd7, 1'b0);
        chk_out("raw.c0", 1'b1, 1'b0, 1'b0);
        step();
        chk_out("raw.c1", 1'b0, 1'b1, 1'b1);
        step();

        // Load-use: lw x7 at t, consumer of x7 stalls at t+1, issues at t+2.
        pair(5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk_out("lu.t0", 1'b1, 1'b0, 1'b1);
        step();
        pair(5'd7, 5'd0, 5'd8, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk_out("lu.t1", 1'b0, 1'b0, 1'b0);
        step();
        chk_out("lu.t2", 1'b1, 1'b0, 1'b1);
        exp_stall = 1;
        chk("lu.stall", 32'(bus.stall_cycles), 32'(exp_stall));
        step();

        // Two loads share one memory port.
        pair(5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 5'd2, 5'd0, 5'd4, 1'b1);
        chk_out("ldld.c0", 1'b1, 1'b0, 1'b0);
        step();
        chk_out("ldld.c1", 1'b0, 1'b1, 1'b1);
        step();

        // WAW on x9 between two ALU ops.
        pair(5'd10, 5'd11, 5'd9, 1'b0, 1'b1, 5'd12, 5'd13, 5'd9, 1'b0);
        chk_out("waw.c0", 1'b1, 1'b0, 1'b0);
        step();
        chk_out("waw.c1", 1'b0, 1'b1, 1'b1);
        step();

        // B source busy from an earlier load: A goes, B follows next cycle.
        pair(5'd0, 5'd0, 5'd20, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk_out("bbusy.ld", 1'b1, 1'b0, 1'b1);
        step();
        pair(5'd1, 5'd2, 5'd21, 1'b0, 1'b1, 5'd20, 5'd0, 5'd22, 1'b0);
        chk_out("bbusy.c0", 1'b1, 1'b0, 1'b0);
        step();
        chk_out("bbusy.c1", 1'b0, 1'b1, 1'b1);
        step();

        // Load in A feeding B: B waits one stall cycle in S_B_ONLY.
        pair(5'd1, 5'd0, 5'd23, 1'b1, 1'b1, 5'd23, 5'd0, 5'd24, 1'b0);
        chk_out("ldb.c0", 1'b1, 1'b0, 1'b0);
        step();
        chk_out("ldb.c1", 1'b0, 1'b0, 1'b0);
        step();
        chk_out("ldb.c2", 1'b0, 1'b1, 1'b1);
        exp_stall = 2;
        chk("ldb.stall", 32'(bus.stall_cycles), 32'(exp_stall));
        step();

        // x0 as load destination and as sources never blocks or splits.
        pair(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        chk_out("x0.c0", 1'b1, 1'b1, 1'b1);
        step();
        pair(5'd0, 5'd0, 5'd25, 1'b0, 1'b1, 5'd0, 5'd0, 5'd26, 1'b0);
        chk_out("x0.c1", 1'b1, 1'b1, 1'b1);
        step();

        // Flush in S_B_ONLY drops B; next pair sees S_PAIR.
        pair(5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 5'd5, 5'd0, 5'd7, 1'b0);
        chk_out("fl.c0", 1'b1, 1'b0, 1'b0);
        step();
        bus.flush = 1'b1;
        chk_out("fl.c1", 1'b0, 1'b0, 1'b0);
        step();
        bus.flush = 1'b0;
        exp_stall = 3;
        chk("fl.stall", 32'(bus.stall_cycles), 32'(exp_stall));
        pair(5'd1, 5'd2, 5'd12, 1'b0, 1'b1, 5'd3, 5'd4, 5'd13, 1'b0);
        chk_out("fl.c2", 1'b1, 1'b1, 1'b1);
        step();

        // Reset while in S_B_ONLY: clean restart in S_PAIR with a cleared counter.
        pair(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 5'd5, 5'd0, 5'd7, 1'b0);
        chk_out("mr.c0", 1'b1, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        chk_out("mr.c1", 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        exp_stall = 0;
        chk("mr.stall", 32'(bus.stall_cycles), 32'(exp_stall));
        pair(5'd5, 5'd2, 5'd12, 1'b0, 1'b1, 5'd5, 5'd4, 5'd13, 1'b0);
        chk_out("mr.c2", 1'b1, 1'b1, 1'b1);
        step();

        // Saturation: 2^16+3 stalled cycles (held by flush) pin the counter at all-ones.
        bus.flush = 1'b1;
        repeat (65539) step();
        chk("sat.stall", 32'(bus.stall_cycles), 32'h0000_ffff);
        step();
        chk("sat.hold", 32'(bus.stall_cycles), 32'h0000_ffff);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
